// File: rtl/proc_run_controller.sv
// proc_run_controller: sequences processor reset, counts run cycles, traces stores, ends on done or timeout.
module proc_run_controller #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    RESET_CYCLES   = 2,
    parameter int                    TRACE_DEPTH    = 16,
    parameter int                    CNT_WIDTH      = 32,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter logic [DATA_WIDTH-1:0] DONE_VALUE     = '1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    output logic                         o_core_reset,
    input  logic                         i_write_en,
    input  logic [DATA_WIDTH-1:0]        i_write_data,
    input  logic                         i_trace_rd_en,
    output logic [DATA_WIDTH-1:0]        o_trace_data,
    output logic                         o_trace_valid,
    output logic [$clog2(TRACE_DEPTH):0] o_trace_count,
    output logic                         o_trace_overflow,
    output logic [CNT_WIDTH-1:0]         o_cycle_count,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_timed_out
);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int HW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DONE, S_TIMEOUT} state_t;

    state_t                r_state;
    logic [HW-1:0]         r_hold;
    logic [DATA_WIDTH-1:0] r_mem [TRACE_DEPTH];
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW:0]           r_count;
    logic                  w_start;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_write;
    logic                  w_done;
    logic                  w_timeout;

    assign w_start   = i_start && (r_state inside {S_IDLE, S_DONE, S_TIMEOUT});
    assign w_full    = r_count == (AW+1)'(TRACE_DEPTH);
    assign w_pop     = i_trace_rd_en && r_count != '0;
    assign w_push    = r_state == S_RUN && i_write_en;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_write   = w_push && (!w_full || w_pop);
    assign w_done    = w_push && i_write_data == DONE_VALUE;
    assign w_timeout = TIMEOUT_CYCLES != 0 && r_state == S_RUN && !w_done &&
                       o_cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    assign o_trace_valid = r_count != '0;
    assign o_trace_count = r_count;
    assign o_trace_data  = o_trace_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_hold        <= '0;
            o_core_reset  <= 1'b1;
            o_cycle_count <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_timed_out   <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_hold <= r_hold - 1'b1;
                    if (r_hold == HW'(1)) begin
                        r_state      <= S_RUN;
                        o_core_reset <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (o_cycle_count != '1)
                        o_cycle_count <= o_cycle_count + 1'b1;
                    if (w_done || w_timeout) begin
                        r_state      <= w_done ? S_DONE : S_TIMEOUT;
                        o_core_reset <= 1'b1;
                        o_busy       <= 1'b0;
                        o_done       <= w_done;
                        o_timed_out  <= !w_done;
                    end
                end
                default: begin
                    if (i_start) begin
                        r_state       <= S_HOLD;
                        r_hold        <= HW'(RESET_CYCLES);
                        o_core_reset  <= 1'b1;
                        o_cycle_count <= '0;
                        o_busy        <= 1'b1;
                        o_done        <= 1'b0;
                        o_timed_out   <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_start) begin
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_count          <= '0;
            o_trace_overflow <= 1'b0;
        end else begin
            if (w_write)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_write) - (AW+1)'(w_pop);
            if (w_push && !w_write)
                o_trace_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_write)
            r_mem[r_wr_ptr] <= i_write_data;
    end
endmodule

// File: tb/tb_proc_run_controller.sv
// tb_proc_run_controller: directed runs with a trace scoreboard checked by a pop monitor.
module tb_proc_run_controller;
    localparam logic [31:0] DONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic        rd_en = 1'b0;
    logic        core_reset;
    logic [31:0] trace_data;
    logic        trace_valid;
    logic [2:0]  trace_count;
    logic        trace_overflow;
    logic [31:0] cycle_count;
    logic        busy;
    logic        done;
    logic        timed_out;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    proc_run_controller #(
        .DATA_WIDTH(32), .RESET_CYCLES(2), .TRACE_DEPTH(4),
        .CNT_WIDTH(32), .TIMEOUT_CYCLES(8), .DONE_VALUE(DONE)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .o_core_reset(core_reset),
        .i_write_en(we), .i_write_data(wd), .i_trace_rd_en(rd_en),
        .o_trace_data(trace_data), .o_trace_valid(trace_valid),
        .o_trace_count(trace_count), .o_trace_overflow(trace_overflow),
        .o_cycle_count(cycle_count), .o_busy(busy), .o_done(done),
        .o_timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] d, input bit kept);
        we = 1'b1;
        wd = d;
        if (kept)
            exp_q.push_back(d);
        step();
        we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // every accepted pop is matched against the next expected trace entry
    always @(negedge clk) begin
        if (rd_en && trace_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL trace_pop: got %h expected no entry", trace_data);
            end else begin
                chk("trace_pop", trace_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_valid", trace_valid, 0);
        chk("rst_count", trace_count, 0);
        chk("rst_data", trace_data, 0);
        chk("rst_ovf", trace_overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_to", timed_out, 0);

        // run 1: reset sequencing and timeout after 8 RUN cycles
        pulse_start();
        chk("hold1_core_reset", core_reset, 1);
        chk("hold1_busy", busy, 1);
        step();
        chk("hold2_core_reset", core_reset, 1);
        step();
        chk("run_core_reset", core_reset, 0);
        chk("run_busy", busy, 1);
        chk("run_cycles0", cycle_count, 0);
        step(5);
        chk("run_cycles5", cycle_count, 5);
        step(2);
        chk("pre_to", timed_out, 0);
        step();
        chk("to_flag", timed_out, 1);
        chk("to_cycles", cycle_count, 8);
        chk("to_done", done, 0);
        chk("to_core_reset", core_reset, 1);
        chk("to_busy", busy, 0);
        step(2);
        chk("to_cycles_hold", cycle_count, 8);

        // run 2: stores ending on DONE, then drain
        pulse_start();
        chk("start_clears_to", timed_out, 0);
        chk("start_clears_cycles", cycle_count, 0);
        step(2);
        store(5, 1);
        store(10, 1);
        store(15, 1);
        store(DONE, 1);
        chk("done_flag", done, 1);
        chk("done_core_reset", core_reset, 1);
        chk("done_count", trace_count, 4);
        chk("done_cycles", cycle_count, 4);
        chk("done_ovf", trace_overflow, 0);
        rd_en = 1'b1;
        step(4);
        rd_en = 1'b0;
        chk("drained_valid", trace_valid, 0);
        chk("drained_data", trace_data, 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("empty_pop_count", trace_count, 0);

        // run 3: ignored Start in HOLD, full push+pop, then overflow
        pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("start_in_hold_ignored", core_reset, 0);
        for (int i = 1; i <= 4; i++)
            store(32'(i), 1);
        chk("full_count", trace_count, 4);
        rd_en = 1'b1;
        store(9, 1);
        rd_en = 1'b0;
        chk("pushpop_count", trace_count, 4);
        chk("pushpop_ovf", trace_overflow, 0);
        chk("pushpop_head", trace_data, 2);
        store(5, 0);
        store(6, 0);
        chk("ovf_count", trace_count, 4);
        chk("ovf_flag", trace_overflow, 1);
        step();
        chk("run3_to", timed_out, 1);
        store(77, 0);
        chk("we_outside_run", trace_count, 4);
        rd_en = 1'b1;
        step(4);
        rd_en = 1'b0;
        chk("run3_drained", trace_valid, 0);
        chk("ovf_sticky", trace_overflow, 1);

        // run 4: reset mid-run with 3 entries logged
        pulse_start();
        step(2);
        store(21, 0);
        store(22, 0);
        store(23, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", trace_count, 0);
        chk("midrst_cycles", cycle_count, 0);
        chk("midrst_ovf", trace_overflow, 0);

        // run 5: DONE on the timeout cycle wins, then Start with a pop clears
        pulse_start();
        step(2);
        chk("rerun_core_reset", core_reset, 0);
        step(6);
        store(32'h33, 1);
        store(DONE, 0);
        chk("tie_done", done, 1);
        chk("tie_to", timed_out, 0);
        chk("tie_cycles", cycle_count, 8);
        chk("tie_count", trace_count, 2);
        rd_en = 1'b1;
        pulse_start();
        rd_en = 1'b0;
        chk("clear_wins_count", trace_count, 0);
        chk("clear_wins_data", trace_data, 0);
        chk("clear_done", done, 0);
        chk("clear_busy", busy, 1);
        step(2);
        chk("run6_core_reset", core_reset, 0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
